// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes and FSM states.
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the magnitude datapath: shift-add multiply or restoring divide.
// Works on a WIDTH+1 bit accumulator so the carry / trial-subtract sign is visible.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_shift,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_shift
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_sum    = {1'b0, i_acc} + (i_shift[0] ? {1'b0, i_opnd} : '0);
        w_rem_sh = {i_acc, i_shift[WIDTH-1]};
        w_diff   = w_rem_sh - {1'b0, i_opnd};
        o_acc    = w_sum[WIDTH:1];
        o_shift  = {w_sum[0], i_shift[WIDTH-1:1]};
        if (i_is_div) begin
            // Partial remainder stays below the divisor, so bit WIDTH of the difference is its sign.
            if (w_diff[WIDTH]) begin
                o_acc   = w_rem_sh[WIDTH-1:0];
                o_shift = {i_shift[WIDTH-2:0], 1'b0};
            end else begin
                o_acc   = w_diff[WIDTH-1:0];
                o_shift = {i_shift[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; also services MTHI/MTLO.
// Operands are held as magnitudes during RUN; FIX restores signs before the HI/LO write.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    mdu_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_opnd;
    logic             r_is_div;
    logic             r_neg;
    logic             r_neg_rem;
    logic             r_div0;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_signed;
    logic             w_is_div;
    logic             w_s1;
    logic             w_s2;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic [WIDTH-1:0] w_acc_nx;
    logic [WIDTH-1:0] w_shift_nx;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_hi_res;
    logic [WIDTH-1:0] w_lo_res;

    assign w_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign w_is_div = (op == MDU_DIV) || (op == MDU_DIVU);
    assign w_s1     = w_signed & in1[WIDTH-1];
    assign w_s2     = w_signed & in2[WIDTH-1];
    assign w_abs1   = w_s1 ? -in1 : in1;
    assign w_abs2   = w_s2 ? -in2 : in2;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_shift  (r_shift),
        .i_opnd   (r_opnd),
        .o_acc    (w_acc_nx),
        .o_shift  (w_shift_nx)
    );

    // Divide by zero keeps the raw all-ones quotient; its remainder re-signs back to in1.
    assign w_prod     = {r_acc, r_shift};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;
    assign w_quo_fix  = r_div0 ? '1 : (r_neg ? -r_shift : r_shift);
    assign w_rem_fix  = r_neg_rem ? -r_acc : r_acc;
    assign w_hi_res   = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_lo_res   = r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_shift   <= '0;
            r_opnd    <= '0;
            r_is_div  <= 1'b0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start && !flush) begin
                        r_state   <= S_RUN;
                        r_cnt     <= '0;
                        r_acc     <= '0;
                        r_shift   <= w_abs1;
                        r_opnd    <= w_abs2;
                        r_is_div  <= w_is_div;
                        r_neg     <= w_s1 ^ w_s2;
                        r_neg_rem <= w_s1;
                        r_div0    <= w_is_div && (in2 == '0);
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc   <= w_acc_nx;
                        r_shift <= w_shift_nx;
                        r_cnt   <= r_cnt + CW'(1);
                        if (r_cnt == CNT_LAST) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    if (!flush) begin
                        r_hi   <= w_hi_res;
                        r_lo   <= w_lo_res;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected {hi,lo}, a monitor pops on done.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         flush;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    logic        prev_done = 1'b0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .in1   (in1),
        .in2   (in2),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit / int arithmetic, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb;
        int     ia, ib;
        case (o)
            2'b00: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return 64'(sa * sb);
            end
            2'b01: return {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                ia = $signed(a);
                ib = $signed(b);
                return {32'(ia % ib), 32'(ia / ib)};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            check("done_not_busy", 64'(busy), 64'd0);
            check("done_one_cycle", 64'(prev_done), 64'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
            end else begin
                check("result", {hi, lo}, exp_q.pop_front());
            end
        end
        prev_done <= done;
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        @(negedge clk);
        op    = o;
        in1   = a;
        in2   = b;
        start = 1'b1;
        if (push) exp_q.push_back(model(o, a, b));
        @(negedge clk);
        start = 1'b0;
        in1   = $urandom;
        in2   = $urandom;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    // Counts negedges until done; start edge plus WIDTH+1 edges means WIDTH+1 samples here.
    task automatic wait_done(input string name, input int exp_n);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n), 64'(exp_n));
    endtask

    logic [1:0]  d_op[8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00};
    logic [31:0] d_a[8]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100,
                             32'd100, 32'h8000_0000, 32'hFFFF_FFF0, 32'h8000_0000};
    logic [31:0] d_b[8]  = '{32'd7, 32'hFFFF_FFFF, 32'd2, 32'd7,
                             32'd0, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; in1 = '0; in2 = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_busy_done", {62'b0, busy, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            issue(d_op[i], d_a[i], d_b[i], 1'b1);
            wait_done("latency", W + 1);
        end

        @(negedge clk); lo_we = 1'b1; wdata = 32'h1234;
        @(negedge clk); lo_we = 1'b0;
        check("mtlo_idle", 64'(lo), 64'h1234);
        hi_we = 1'b1; wdata = 32'hABCD;
        @(negedge clk); hi_we = 1'b0;
        check("mthi_idle", 64'(hi), 64'hABCD);

        @(negedge clk);
        op = 2'b01; in1 = 32'd6; in2 = 32'd7; start = 1'b1; lo_we = 1'b1; wdata = 32'h5555;
        exp_q.push_back(model(2'b01, 32'd6, 32'd7));
        @(negedge clk); start = 1'b0; lo_we = 1'b0;
        check("mtlo_with_start", 64'(lo), 64'h5555);
        wait_done("latency_mtlo_start", W + 1);

        issue(2'b01, 32'd3, 32'd4, 1'b1);
        repeat (5) @(negedge clk);
        op = 2'b11; in1 = 32'd100; in2 = 32'd7; start = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
        @(negedge clk); start = 1'b0; lo_we = 1'b0;
        check("mtlo_busy_dropped", 64'(lo), 64'd42);
        wait_done("latency_start_ignored", W + 1 - 6);
        repeat (40) @(negedge clk);
        check("idle_after_ignored_start", 64'(busy), 64'd0);

        issue(2'b00, 32'd5, 32'd5, 1'b0);
        repeat (9) @(negedge clk);
        start = 1'b1; in1 = 32'd9; in2 = 32'd9;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hilo_kept", {hi, lo}, {32'd0, 32'd12});
        repeat (40) @(negedge clk);
        check("flush_stays_idle", 64'(busy), 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            issue(ro, ra, rb, 1'b1);
            wait_done("latency_rand", W + 1);
        end

        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done("latency_pre_reset", W + 1);
        issue(2'b10, 32'd100, 32'd3, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_busy_done", {62'b0, busy, done}, 64'd0);
        check("async_reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk); rst = 1'b0;

        issue(2'b11, 32'd100, 32'd7, 1'b1);
        wait_done("latency_after_reset", W + 1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
